// File: rtl/seq_pipe_elastic_2entry_pkg.sv
// Shared types and constants for the two-entry elastic pipeline receiver.
package seq_pipe_elastic_2entry_pkg;

    // Default message width in bits.
    localparam int P_NBITS_DEFAULT = 8;

    // Buffer occupancy: the state is simply how many messages are held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_pipe_elastic_reg.sv
// Enable register with synchronous active-low clear, used for the head and tail slots.
module seq_pipe_elastic_reg #(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic [p_nbits-1:0] d_i,
    output logic [p_nbits-1:0] q_o
);

    logic [p_nbits-1:0] data_q;

    // Load on enable; clear to zero while reset is held low.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    // NOTE: the data slot is cleared on reset because out_msg must read 0 after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/seq_pipe_elastic_2entry.sv
// Two-entry elastic receiver: val/rdy in, val/rdy out, strict FIFO order,
// all outputs driven from registers so no combinational path crosses the block.
module seq_pipe_elastic_2entry
    import seq_pipe_elastic_2entry_pkg::*;
#(
    parameter int p_nbits = P_NBITS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg
);

    state_e             state_q;
    state_e             state_d;
    logic               enq;
    logic               deq;
    logic               head_en;
    logic               tail_en;
    logic               head_from_tail;
    logic [p_nbits-1:0] head_d;
    logic [p_nbits-1:0] head_q;
    logic [p_nbits-1:0] tail_q;

    // Fired handshakes; in_rdy/out_val depend only on state_q.
    assign enq = in_val && in_rdy;
    assign deq = out_val && out_rdy;

    // Head loads either the incoming message or the promoted tail.
    assign head_d = head_from_tail ? tail_q : in_msg;

    // Occupancy register; reset overrides any simultaneous handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and slot load enables from the fired handshakes.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d        = state_q;
        head_en        = 1'b0;
        tail_en        = 1'b0;
        head_from_tail = 1'b0;
        case (state_q)
            EMPTY: begin
                if (enq) begin
                    state_d = ONE;
                    head_en = 1'b1;
                end
            end
            ONE: begin
                if (enq && !deq) begin
                    state_d = FULL;
                    tail_en = 1'b1;
                end else if (!enq && deq) begin
                    state_d = EMPTY;
                end else if (enq && deq) begin
                    // Pass-through: the new message replaces the departing head.
                    head_en = 1'b1;
                end
            end
            FULL: begin
                // in_rdy is low here, so only a dequeue can happen.
                if (deq) begin
                    state_d        = ONE;
                    head_en        = 1'b1;
                    head_from_tail = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Registered-only outputs derived from occupancy and the head slot.
    always_comb begin
        in_rdy  = (state_q != FULL);
        out_val = (state_q != EMPTY);
        out_msg = head_q;
    end

    seq_pipe_elastic_reg #(
        .p_nbits (p_nbits)
    ) u_head (
        .clk   (clk),
        .reset (reset),
        .en_i  (head_en),
        .d_i   (head_d),
        .q_o   (head_q)
    );

    seq_pipe_elastic_reg #(
        .p_nbits (p_nbits)
    ) u_tail (
        .clk   (clk),
        .reset (reset),
        .en_i  (tail_en),
        .d_i   (in_msg),
        .q_o   (tail_q)
    );

endmodule

// File: tb/tb_seq_pipe_elastic_2entry.sv
// Self-checking bench: directed scenarios plus random traffic, with a
// queue-based reference of held messages checked by a negedge monitor.
module tb_seq_pipe_elastic_2entry;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_msg;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_msg;

    int n_checks = 0;
    int n_fail   = 0;
    int n_deq    = 0;

    // Reference: messages currently held, oldest first (at most two).
    logic [7:0] model_q[$];
    bit         model_live = 1'b0;

    seq_pipe_elastic_2entry #(
        .p_nbits (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs now (posedge+1), then advance to just after the next edge.
    task automatic tick(input logic v, input logic [7:0] m, input logic r);
        in_val  = v;
        in_msg  = m;
        out_rdy = r;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare flow control with the reference occupancy, pop and
    // compare on every dequeue the DUT presents, and record enqueues.
    always @(negedge clk) begin : monitor
        logic enq_fire;
        if (!reset) begin
            model_q.delete();
            model_live = 1'b1;
        end else if (model_live) begin
            check("in_rdy", in_rdy, model_q.size() < 2);
            check("out_val", out_val, model_q.size() != 0);
            if (out_val) check("out_msg_known", $isunknown(out_msg), 0);
            enq_fire = in_val && (model_q.size() < 2);
            if (out_val && out_rdy) begin
                if (model_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    check("out_msg", out_msg, model_q[0]);
                    void'(model_q.pop_front());
                    n_deq++;
                end
            end
            if (enq_fire) model_q.push_back(in_msg);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [7:0] rand_msgs[20];
        int         sent;
        int         budget;
        int         base_deq;

        // Reset held for two edges with in_val asserted.
        reset   = 1'b0;
        in_val  = 1'b1;
        in_msg  = 8'hff;
        out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_out_val", out_val, 0);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_msg", out_msg, 8'h00);

        // Streaming at full throughput.
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 8'h0a + 8'(i), 1'b1);
            check("stream_out_msg", out_msg, 8'h0a + 8'(i));
            check("stream_in_rdy", in_rdy, 1);
        end
        tick(1'b0, 8'h00, 1'b1);
        check("stream_drained", out_val, 0);

        // Stall and fill: 33 must wait until space frees up.
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h22, 1'b0);
        check("fill_in_rdy", in_rdy, 0);
        tick(1'b1, 8'h33, 1'b0);
        check("fill_hold_rdy", in_rdy, 0);
        check("fill_head", out_msg, 8'h11);
        tick(1'b1, 8'h33, 1'b1);
        check("fill_deq1", out_msg, 8'h22);
        check("fill_rdy_back", in_rdy, 1);
        tick(1'b1, 8'h33, 1'b1);
        check("fill_deq2", out_msg, 8'h33);
        tick(1'b0, 8'h00, 1'b1);
        check("fill_drained", out_val, 0);

        // Simultaneous enqueue and dequeue while holding one message.
        tick(1'b1, 8'h44, 1'b0);
        check("pass_head", out_msg, 8'h44);
        tick(1'b1, 8'h55, 1'b1);
        check("pass_out_msg", out_msg, 8'h55);
        check("pass_out_val", out_val, 1);
        check("pass_in_rdy", in_rdy, 1);
        tick(1'b0, 8'h00, 1'b1);

        // Reset while full discards both messages.
        tick(1'b1, 8'h66, 1'b0);
        tick(1'b1, 8'h77, 1'b0);
        check("mid_full", in_rdy, 0);
        reset = 1'b0;
        tick(1'b1, 8'h99, 1'b1);
        reset = 1'b1;
        check("mid_rst_out_val", out_val, 0);
        check("mid_rst_in_rdy", in_rdy, 1);
        check("mid_rst_out_msg", out_msg, 8'h00);
        tick(1'b1, 8'h88, 1'b1);
        check("mid_first_out", out_msg, 8'h88);
        tick(1'b0, 8'h00, 1'b1);

        // Random traffic; each message is held on in_msg until accepted.
        foreach (rand_msgs[i]) rand_msgs[i] = 8'($urandom);
        base_deq = n_deq;
        sent     = 0;
        budget   = 0;
        while (sent < 20 && budget < 2000) begin
            logic v;
            logic r;
            logic [7:0] m;
            v = ($urandom % 4) != 0;
            r = ($urandom % 2) != 0;
            m = rand_msgs[sent];
            if (v && in_rdy) sent++;
            tick(v, m, r);
            budget++;
        end
        check("rand_sent", 8'(sent), 8'd20);
        budget = 0;
        while (out_val && budget < 50) begin
            tick(1'b0, 8'h00, 1'b1);
            budget++;
        end
        tick(1'b0, 8'h00, 1'b1);
        check("rand_drained", out_val, 0);
        check("rand_received", 8'(n_deq - base_deq), 8'd20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
